// File: rtl/stage_if_queued_pkg.sv
// Shared definitions for the queued fetch stage: FSM encoding and fetch constants.
package stage_if_queued_pkg;

    // Fetch request FSM: idle, waiting on a live response, or waiting on a stale one.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/stage_if_queued_fetch_queue.sv
// Circular FIFO buffering fetched {pc, instr} pairs; flush and reset empty it in one cycle.
import stage_if_queued_pkg::*;

module fetch_queue #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; flush discards everything, including this cycle's push/pop.
    always_comb begin
        do_push  = push_i && !flush_i && (!full_o || pop_i);
        do_pop   = pop_i && !flush_i && !empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/stage_if_queued.sv
// Queued instruction fetch stage: one outstanding imem request, DEPTH-entry fetch queue to decode.
// Optional performance counters are enabled by defining STAGE_IF_PERF_EN.
import stage_if_queued_pkg::*;

module stage_if_queued #(
    parameter int unsigned          XLEN     = 64,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          ILEN     = INSTR_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  if_pc,
    output logic [ILEN-1:0]  if_instr
`ifdef STAGE_IF_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushes
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_state_e        state_q, state_d;
    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]     req_pc_q, req_pc_d;

    logic                q_push, q_pop, q_flush;
    logic [XLEN+ILEN-1:0] q_head;
    logic [CW-1:0]       q_count;
    logic                q_empty, q_full;
    logic                q_has_room;

    fetch_queue #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .din_i   ({req_pc_q, imem_rdata}),
        .head_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    assign q_has_room = (q_count < CW'(DEPTH));
    assign q_flush    = redirect_valid;
    assign q_pop      = if_valid && if_ready && !redirect_valid;
    assign if_valid   = !q_empty;
    assign if_pc      = q_head[XLEN+ILEN-1:ILEN];
    assign if_instr   = q_head[ILEN-1:0];
    assign imem_addr  = fetch_pc_q;

    // Issue/response FSM: request only when idle with room; redirect retargets and marks in-flight data stale.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        q_push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && !rst && q_has_room) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    q_push  = !redirect_valid;
                    state_d = S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_target & ~XLEN'(3);
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // A push into a full queue without a pop would mean more than one request was in flight.
    always_ff @(posedge clk) begin
        assert (rst || !(q_push && q_full && !q_pop));
    end

`ifdef STAGE_IF_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushes_q;

    // Free-running event counters: instructions handed to decode and redirect cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (q_pop)          perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect_valid) perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule
